mnist_neuron_bank: RTL and testbench
====================================

Name: mnist_neuron_bank

Overview:
- Responder side of the classifier controller's interface. The controller issues one-hot bias load strobes and a sequential pixel address stream. This block answers with the computed classification.
- Holds one signed accumulator per output class. Accumulators are preloaded from bias strobes, then multiply-accumulate each incoming pixel against its per-class weights.
- After the last pixel, a sequential argmax runs and the winning digit is presented on a valid/ack handshake.
- Sits between the controller plus pixel/weight/bias ROMs and the result display logic.

Parameters:
- NUM_CLASSES, 10, number of output neurons/digits (max 12, the width of bias_load).
- NUM_PIXELS, 784, pixels per image; pixel_addr runs 0..NUM_PIXELS-1.
- PIX_W, 8, unsigned pixel width.
- WT_W, 8, signed weight width.
- BIAS_W, 16, signed bias width.
- ACC_W, 32, signed accumulator width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- bias_load  in  12  one-hot bias strobe; bit i loads class i
- bias_data  in  BIAS_W  signed bias value for the strobed class
- pixel_valid  in  1  pixel_addr/pixel_data/weight_data are valid this cycle
- pixel_ready  out  1  block accepts pixels this cycle
- pixel_addr  in  12  address of the current pixel
- pixel_data  in  PIX_W  unsigned pixel value
- weight_data  in  NUM_CLASSES*WT_W  signed weights; slice i belongs to class i
- result_valid  out  1  digit/max_score valid
- result_ack  in  1  consumer accepts result
- digit  out  4  winning class index
- max_score  out  ACC_W  winning accumulator value
- addr_err  out  1  sticky flag: out-of-sequence pixel address seen

Behaviour:
- Reset: synchronous, sampled on rising clk while rst_n=0. Reset takes priority over all other activity, including mid-ACCUM and mid-ARGMAX.
- Reset values: state=IDLE; all accumulators=0; expected address=0; pixel_ready=1; result_valid=0; digit=0; max_score=0; addr_err=0.
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - Each bit i<NUM_CLASSES set in bias_load loads acc[i] with sign-extended bias_data.
  - Multiple bits set loads all flagged classes with the same value.
  - Bits at or above NUM_CLASSES are ignored.
  - An accepted pixel (pixel_valid & pixel_ready) moves the block to ACCUM and is itself accumulated.
  - If a bias strobe and a pixel arrive in the same cycle, the bias loads first, and the product is then added to the freshly loaded value.
- ACCUM:
  - Each accepted pixel does acc[i] <= acc[i] + sext(zext(pixel_data) * weight[i]) for every class, in a single cycle.
  - Accumulators wrap at ACC_W bits (two's complement); there is no saturation.
  - bias_load is ignored.
  - If pixel_addr differs from the expected address, addr_err is set to 1 and stays set until reset. The pixel is still accumulated.
  - The expected address increments on every accepted pixel.
  - When the accepted pixel's address is NUM_PIXELS-1 (by expected count), go to ARGMAX next cycle. The expected address clears to 0.
- pixel_ready is 1 only in IDLE and ACCUM. pixel_valid is ignored in ARGMAX and DONE.
- ARGMAX:
  - Scan index k runs 0..NUM_CLASSES-1, one class per cycle.
  - k=0 loads best=acc[0], best_idx=0 unconditionally.
  - k>0 replaces best only if acc[k] > best (signed, strict). Ties keep the lower index.
  - After k=NUM_CLASSES-1, go to DONE.
- Latency: if the last pixel is accepted in cycle T, result_valid rises in cycle T+NUM_CLASSES+1 (T+11 by default).
- DONE:
  - result_valid=1.
  - digit and max_score hold stable until the handshake completes.
  - On result_ack=1: result_valid falls next cycle, the state returns to IDLE, and the accumulators keep their values until new biases are loaded.
  - result_ack in any other state has no effect.
- No start pulse is needed. The next image begins with fresh bias strobes in IDLE.
- Biases that are not reloaded retain their old accumulator values. The controller is responsible for reloading all classes.

Decomposition:
- Shared package mnist_pkg:
  - NUM_CLASSES, NUM_PIXELS, PIX_W, WT_W, BIAS_W, ACC_W.
  - State encoding for IDLE/ACCUM/ARGMAX/DONE.
  - Address width constant (12).
- One natural sub-module: mnist_mac_lane. It holds one class's accumulator with bias-load and MAC, and is instantiated NUM_CLASSES times via generate.
- Argmax scan and FSM stay in the top.

Test Plan:
- Bias-only: load biases 0..9 = {5,-3,7,100,0,0,0,0,0,-1} and stream 784 zero pixels with zero weights -> digit=3, max_score=100, result_valid at T+11.
- Single-pixel weight: all biases 0; pixel 200 at addr 10 with weight[7]=+2, all other weights 0, all other pixels 0 -> digit=7, max_score=400.
- Tie: biases class2=class6=50, all others 0, zero pixels -> digit=2.
- Negative wrap: bias class0 = -32768 with weights -128 and pixels 255 throughout -> acc[0] = -32768 - 784*32640, no saturation; another class with bias 0 wins.
- Address error: skip addr 5 (send 4 then 6) -> addr_err=1 after that cycle and remains 1 through DONE; result still produced.
- Reset mid-ARGMAX: drive rst_n=0 at T+4 -> next cycle state IDLE, result_valid=0, accumulators 0, pixel_ready=1; hold result_ack in DONE for 3 cycles late -> digit stable until ack.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST output neuron bank.
package mnist_pkg;

   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned NUM_PIXELS  = 784;
   localparam int unsigned PIX_W       = 8;
   localparam int unsigned WT_W        = 8;
   localparam int unsigned BIAS_W      = 16;
   localparam int unsigned ACC_W       = 32;
   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned BIAS_SEL_W  = 12;
   localparam int unsigned IDX_W       = 4;
   // Zero-extended pixel (PIX_W+1, signed) times signed weight.
   localparam int unsigned PROD_W      = PIX_W + WT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_ARGMAX,
      ST_DONE
   } state_e;

   typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mnist_mac_lane.sv
// One output neuron: bias preload plus pixel*weight multiply-accumulate.
module mnist_mac_lane
   import mnist_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_i,
   input  logic signed [BIAS_W-1:0] bias_i,
   input  logic                     mac_en_i,
   input  logic        [PIX_W-1:0]  pix_i,
   input  logic signed [WT_W-1:0]   wt_i,
   output acc_t                     acc_o
);

   acc_t                     acc_q;
   acc_t                     acc_d;
   acc_t                     base;
   logic signed [PROD_W-1:0] prod;

   // Bias load happens before the MAC so a same-cycle pixel adds onto the new bias.
   always_comb begin
      prod  = PROD_W'(signed'({1'b0, pix_i})) * PROD_W'(wt_i);
      base  = load_i ? ACC_W'(bias_i) : acc_q;
      acc_d = mac_en_i ? base + ACC_W'(prod) : base;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mnist_neuron_bank.sv
// Per-class accumulator bank with address-sequence check, sequential argmax
// and a valid/ack result port.
module mnist_neuron_bank
   import mnist_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [BIAS_SEL_W-1:0]         bias_load,
   input  logic signed [BIAS_W-1:0]      bias_data,
   input  logic                          pixel_valid,
   output logic                          pixel_ready,
   input  logic [ADDR_W-1:0]             pixel_addr,
   input  logic [PIX_W-1:0]              pixel_data,
   input  logic [NUM_CLASSES*WT_W-1:0]   weight_data,
   output logic                          result_valid,
   input  logic                          result_ack,
   output logic [IDX_W-1:0]              digit,
   output logic signed [ACC_W-1:0]       max_score,
   output logic                          addr_err
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
   logic [IDX_W-1:0]  scan_q, scan_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [IDX_W-1:0]  digit_q, digit_d;
   acc_t              best_q, best_d;
   acc_t              score_q, score_d;
   logic              err_q, err_d;
   logic              ready_q;
   logic              valid_q;

   logic              idle;
   logic              accept;
   logic              last_pix;
   acc_t              cand;
   acc_t              acc [NUM_CLASSES];

   assign idle   = (state_q == ST_IDLE);
   assign accept = pixel_valid & ready_q;

   for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_lane
      mnist_mac_lane u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (idle & bias_load[i]),
         .bias_i   (bias_data),
         .mac_en_i (accept),
         .pix_i    (pixel_data),
         .wt_i     (weight_data[i*WT_W +: WT_W]),
         .acc_o    (acc[i])
      );
   end

   // Strobe bits above the populated classes have no lane behind them.
   if (NUM_CLASSES < BIAS_SEL_W) begin : g_unused_strobe
      logic unused_bias_hi;
      assign unused_bias_hi = ^bias_load[BIAS_SEL_W-1:NUM_CLASSES];
   end

   always_comb begin
      state_d    = state_q;
      exp_addr_d = exp_addr_q;
      scan_d     = scan_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      digit_d    = digit_q;
      score_d    = score_q;
      err_d      = err_q;
      cand       = acc[scan_q];
      last_pix   = (exp_addr_q == ADDR_W'(NUM_PIXELS - 1));

      // End of image is decided by the pixel count, not by the address received.
      if (accept) begin
         if (pixel_addr != exp_addr_q) begin
            err_d = 1'b1;
         end
         if (last_pix) begin
            exp_addr_d = '0;
            state_d    = ST_ARGMAX;
         end else begin
            exp_addr_d = exp_addr_q + ADDR_W'(1);
            state_d    = ST_ACCUM;
         end
      end

      case (state_q)
         ST_ARGMAX: begin
            // Strict compare keeps the lowest index on ties.
            if ((scan_q == '0) || (cand > best_q)) begin
               best_d     = cand;
               best_idx_d = scan_q;
            end
            if (scan_q == IDX_W'(NUM_CLASSES - 1)) begin
               scan_d  = '0;
               digit_d = best_idx_d;
               score_d = best_d;
               state_d = ST_DONE;
            end else begin
               scan_d = scan_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (result_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         exp_addr_q <= '0;
         scan_q     <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         digit_q    <= '0;
         score_q    <= '0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_addr_q <= exp_addr_d;
         scan_q     <= scan_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         digit_q    <= digit_d;
         score_q    <= score_d;
         err_q      <= err_d;
         ready_q    <= (state_d == ST_IDLE) || (state_d == ST_ACCUM);
         valid_q    <= (state_d == ST_DONE);
      end
   end

   assign pixel_ready  = ready_q;
   assign result_valid = valid_q;
   assign digit        = digit_q;
   assign max_score    = score_q;
   assign addr_err     = err_q;

endmodule

// File: tb/tb_mnist_neuron_bank.sv
// Directed bench for mnist_neuron_bank with a reference accumulator model and
// a result scoreboard.
module tb_mnist_neuron_bank;
   import mnist_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [BIAS_SEL_W-1:0]        bias_load;
   logic signed [BIAS_W-1:0]     bias_data;
   logic                         pixel_valid;
   logic                         pixel_ready;
   logic [ADDR_W-1:0]            pixel_addr;
   logic [PIX_W-1:0]             pixel_data;
   logic [NUM_CLASSES*WT_W-1:0]  weight_data;
   logic                         result_valid;
   logic                         result_ack;
   logic [IDX_W-1:0]             digit;
   logic signed [ACC_W-1:0]      max_score;
   logic                         addr_err;

   mnist_neuron_bank dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bias_load    (bias_load),
      .bias_data    (bias_data),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .pixel_addr   (pixel_addr),
      .pixel_data   (pixel_data),
      .weight_data  (weight_data),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .digit        (digit),
      .max_score    (max_score),
      .addr_err     (addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   digit;
      acc_t score;
   } exp_t;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb [$];
   acc_t m_acc [NUM_CLASSES];
   int   pix_mem [NUM_PIXELS];
   int   wt_mem  [NUM_PIXELS][NUM_CLASSES];

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int p = 0; p < NUM_PIXELS; p++) begin
         pix_mem[p] = 0;
         for (int c = 0; c < NUM_CLASSES; c++) wt_mem[p][c] = 0;
      end
   endtask

   task automatic load_bias(input logic [BIAS_SEL_W-1:0] mask, input int val);
      bias_load = mask;
      bias_data = BIAS_W'(val);
      step();
      bias_load = '0;
      for (int c = 0; c < NUM_CLASSES; c++) if (mask[c]) m_acc[c] = ACC_W'(val);
   endtask

   // skip>=0: addresses from index skip onward are sent one too high.
   // junk_at>=0: an all-ones bias strobe rides along with that pixel.
   task automatic stream(input int skip, input int junk_at);
      for (int k = 0; k < NUM_PIXELS; k++) begin
         pixel_valid = 1'b1;
         pixel_addr  = ADDR_W'((skip >= 0 && k >= skip) ? k + 1 : k);
         pixel_data  = PIX_W'(pix_mem[k]);
         for (int c = 0; c < NUM_CLASSES; c++)
            weight_data[c*WT_W +: WT_W] = WT_W'(wt_mem[k][c]);
         if (k == junk_at) begin
            bias_load = '1;
            bias_data = 16'sh7FFF;
         end
         step();
         bias_load = '0;
         for (int c = 0; c < NUM_CLASSES; c++)
            m_acc[c] = m_acc[c] + ACC_W'(pix_mem[k] * wt_mem[k][c]);
         if (skip > 0 && k == skip - 1) chk("addr_err_before_skip", addr_err, 0);
         if (skip >= 0 && k == skip)    chk("addr_err_at_skip", addr_err, 1);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic push_expected();
      exp_t e;
      e.digit = 0;
      e.score = m_acc[0];
      for (int c = 1; c < NUM_CLASSES; c++) begin
         if (m_acc[c] > e.score) begin
            e.digit = c;
            e.score = m_acc[c];
         end
      end
      sb.push_back(e);
   endtask

   // Called in the cycle after the last pixel was accepted.
   task automatic collect(input int ack_delay);
      exp_t e;
      int   lat;
      lat = 1;
      while (result_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      chk("result_latency", lat, NUM_CLASSES + 1);
      chk("result_valid_seen", result_valid, 1);
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("digit", digit, e.digit);
         chk("max_score", max_score, e.score);
         chk("ready_low_done", pixel_ready, 0);
         for (int d = 0; d < ack_delay; d++) begin
            step();
            chk("valid_held", result_valid, 1);
            chk("digit_held", digit, e.digit);
            chk("score_held", max_score, e.score);
         end
      end
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("valid_fall", result_valid, 0);
      chk("ready_back", pixel_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bias_load   = '0;
      bias_data   = '0;
      pixel_valid = 1'b0;
      pixel_addr  = '0;
      pixel_data  = '0;
      weight_data = '0;
      result_ack  = 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) m_acc[c] = '0;
      step();
      step();
      chk("rst_pixel_ready", pixel_ready, 1);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_digit", digit, 0);
      chk("rst_max_score", max_score, 0);
      chk("rst_addr_err", addr_err, 0);
      rst_n = 1'b1;
      // ack outside DONE must do nothing
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk("idle_ack_ignored", result_valid, 0);

      // Bias-only image
      clear_mem();
      load_bias(12'h001, 5);
      load_bias(12'h002, -3);
      load_bias(12'h004, 7);
      load_bias(12'h008, 100);
      load_bias(12'h1F0, 0);
      load_bias(12'h200, -1);
      stream(-1, -1);
      push_expected();
      collect(0);
      chk("addr_err_clean", addr_err, 0);

      // Single contributing pixel; bias strobe coincides with pixel 0
      clear_mem();
      load_bias(12'h3FF, 0);
      pix_mem[10]   = 200;
      wt_mem[10][7] = 2;
      pix_mem[0]    = 1;
      wt_mem[0][3]  = 5;
      bias_load     = 12'h008;
      bias_data     = 16'sd10;
      m_acc[3]      = 10;
      stream(-1, -1);
      push_expected();
      collect(0);

      // Tie between classes 2 and 6; strobe bits above the classes are ignored
      clear_mem();
      load_bias(12'h3FF, 0);
      load_bias(12'h044, 50);
      load_bias(12'hC00, 999);
      stream(-1, -1);
      push_expected();
      collect(3);

      // Large negative class 0; bias strobe mid-image must be ignored
      clear_mem();
      for (int p = 0; p < NUM_PIXELS; p++) begin
         pix_mem[p]   = 255;
         wt_mem[p][0] = -128;
      end
      load_bias(12'h3FE, 0);
      load_bias(12'h001, -32768);
      stream(-1, 100);
      push_expected();
      collect(1);

      // Random image with address 5 skipped
      for (int p = 0; p < NUM_PIXELS; p++) begin
         pix_mem[p] = int'($urandom_range(255));
         for (int c = 0; c < NUM_CLASSES; c++) wt_mem[p][c] = int'($urandom_range(255)) - 128;
      end
      for (int c = 0; c < NUM_CLASSES; c++) load_bias(BIAS_SEL_W'(1) << c, int'($urandom_range(65535)) - 32768);
      stream(5, -1);
      chk("addr_err_accum_end", addr_err, 1);
      push_expected();
      collect(0);
      chk("addr_err_sticky", addr_err, 1);

      // Reset in the middle of the argmax scan
      clear_mem();
      load_bias(12'h3FF, 0);
      load_bias(12'h008, 100);
      stream(-1, -1);
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < NUM_CLASSES; c++) m_acc[c] = '0;
      chk("midrst_result_valid", result_valid, 0);
      chk("midrst_pixel_ready", pixel_ready, 1);
      chk("midrst_addr_err", addr_err, 0);
      chk("midrst_digit", digit, 0);
      chk("midrst_max_score", max_score, 0);
      for (int d = 0; d < 15; d++) begin
         step();
         chk("midrst_no_result", result_valid, 0);
      end
      stream(-1, -1);
      push_expected();
      collect(0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
